// File: rtl/quad_encoder_gen.sv
// -----------------------------------------------------------------------------
// quad_encoder_gen
//
// Quadrature encoder emulator. Accepts a command (direction, cycles per
// quadrature edge, number of edges with 0 meaning "run until stopped") and
// drives A/B exactly as a physical incremental encoder would. It also keeps a
// signed, wrapping count of the edges it has emitted.
//
// Ports
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   cmd_valid   in   command presented
//   cmd_ready   out  command accepted this cycle when high (IDLE only)
//   cmd_dir     in   1 = forward (B leads A), 0 = reverse
//   cmd_period  in   clock cycles between quadrature edges (values < 2 act as 2)
//   cmd_steps   in   quadrature edges to emit, 0 = continuous
//   stop        in   abort the current run (ignored in IDLE)
//   outA, outB  out  registered quadrature outputs
//   busy        out  high while a run is active
//   done        out  one-cycle pulse when a run ends (completion or stop)
//   position    out  signed edge count, +1 forward / -1 reverse, wraps
// -----------------------------------------------------------------------------
module quad_encoder_gen #(
    parameter int PERIOD_W = 16,
    parameter int STEPS_W  = 16,
    parameter int POS_W    = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_dir,
    input  logic [PERIOD_W-1:0]        cmd_period,
    input  logic [STEPS_W-1:0]         cmd_steps,
    input  logic                       stop,
    output logic                       outA,
    output logic                       outB,
    output logic                       busy,
    output logic                       done,
    output logic signed [POS_W-1:0]    position
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Next (A,B) in the requested direction. Forward walks 00->01->11->10,
    // reverse walks the same ring backwards, so exactly one bit flips per step.
    function automatic logic [1:0] next_phase(input logic fwd, input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = fwd ? 2'b01 : 2'b10;
            2'b01:   nxt = fwd ? 2'b11 : 2'b00;
            2'b11:   nxt = fwd ? 2'b10 : 2'b01;
            2'b10:   nxt = fwd ? 2'b00 : 2'b11;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    state_t              state_q,     state_d;
    logic                dir_q,       dir_d;
    logic [PERIOD_W-1:0] period_q,    period_d;
    logic [PERIOD_W-1:0] div_q,       div_d;
    logic [STEPS_W-1:0]  remaining_q, remaining_d;
    logic                cont_q,      cont_d;
    logic [1:0]          ab_q,        ab_d;
    logic [POS_W-1:0]    pos_q,       pos_d;
    logic                busy_q,      busy_d;
    logic                ready_q,     ready_d;
    logic                done_q,      done_d;

    logic                edge_due_s;
    logic [PERIOD_W-1:0] period_in_s;

    // Edge is due on the last cycle of the period; period_q is never below 2,
    // so period_q - 1 cannot underflow.
    always_comb begin
        edge_due_s = (div_q == (period_q - PERIOD_W'(1)));
    end

    // Clamp the commanded period so edges are never closer than 2 cycles.
    always_comb begin
        if (cmd_period < PERIOD_W'(2)) begin
            period_in_s = PERIOD_W'(2);
        end else begin
            period_in_s = cmd_period;
        end
    end

    // Next-state and next-output computation for the IDLE/RUN controller.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        period_d    = period_q;
        div_d       = div_q;
        remaining_d = remaining_q;
        cont_d      = cont_q;
        ab_d        = ab_q;
        pos_d       = pos_q;
        busy_d      = busy_q;
        ready_d     = ready_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // stop is deliberately not looked at here.
                if (cmd_valid && ready_q) begin
                    state_d     = ST_RUN;
                    dir_d       = cmd_dir;
                    period_d    = period_in_s;
                    div_d       = {PERIOD_W{1'b0}};
                    remaining_d = cmd_steps;
                    cont_d      = (cmd_steps == {STEPS_W{1'b0}});
                    busy_d      = 1'b1;
                    ready_d     = 1'b0;
                end else begin
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // Abort wins over any edge due this cycle: outputs and
                    // position are left untouched.
                    state_d     = ST_IDLE;
                    div_d       = {PERIOD_W{1'b0}};
                    remaining_d = {STEPS_W{1'b0}};
                    busy_d      = 1'b0;
                    ready_d     = 1'b1;
                    done_d      = 1'b1;
                end else if (edge_due_s) begin
                    div_d = {PERIOD_W{1'b0}};
                    ab_d  = next_phase(dir_q, ab_q);
                    if (dir_q) begin
                        pos_d = pos_q + POS_W'(1);
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                    if (cont_q) begin
                        remaining_d = remaining_q;
                    end else if (remaining_q == STEPS_W'(1)) begin
                        // Final edge: emitted and run closed on the same clock.
                        state_d     = ST_IDLE;
                        remaining_d = {STEPS_W{1'b0}};
                        busy_d      = 1'b0;
                        ready_d     = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        remaining_d = remaining_q - STEPS_W'(1);
                    end
                end else begin
                    div_d = div_q + PERIOD_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                div_d       = {PERIOD_W{1'b0}};
                remaining_d = {STEPS_W{1'b0}};
                busy_d      = 1'b0;
                ready_d     = 1'b1;
            end
        endcase
    end

    // State and registered outputs; the A/B phase is only cleared by reset
    // so consecutive runs continue the quadrature sequence seamlessly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= 1'b0;
            period_q    <= PERIOD_W'(2);
            div_q       <= {PERIOD_W{1'b0}};
            remaining_q <= {STEPS_W{1'b0}};
            cont_q      <= 1'b0;
            ab_q        <= 2'b00;
            pos_q       <= {POS_W{1'b0}};
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            period_q    <= period_d;
            div_q       <= div_d;
            remaining_q <= remaining_d;
            cont_q      <= cont_d;
            ab_q        <= ab_d;
            pos_q       <= pos_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign outA      = ab_q[1];
    assign outB      = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_gen
//
// Directed bench for quad_encoder_gen. Inputs change 1 time unit after a
// rising clock edge and outputs are sampled there too, so the values seen
// after tick() are the ones registered at that edge. All expected phases and
// positions are written out by hand.
// -----------------------------------------------------------------------------
module tb_quad_encoder_gen;

    localparam int PERIOD_W = 16;
    localparam int STEPS_W  = 16;
    localparam int POS_W    = 32;

    logic                    clk;
    logic                    reset_n;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_dir;
    logic [PERIOD_W-1:0]     cmd_period;
    logic [STEPS_W-1:0]      cmd_steps;
    logic                    stop;
    logic                    outA;
    logic                    outB;
    logic                    busy;
    logic                    done;
    logic signed [POS_W-1:0] position;

    int         errors;
    int         checks;
    logic [1:0] cur_ab;

    quad_encoder_gen #(
        .PERIOD_W(PERIOD_W),
        .STEPS_W (STEPS_W),
        .POS_W   (POS_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_period(cmd_period),
        .cmd_steps (cmd_steps),
        .stop      (stop),
        .outA      (outA),
        .outB      (outB),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold for per-1 cycles (A/B must not move, run must stay busy), then
    // expect the edge exp_ab with position exp_pos on the per-th cycle.
    task automatic wait_edge(input int per, input logic [1:0] exp_ab,
                             input int exp_pos, input logic last, input string tag);
        for (int i = 0; i < per - 1; i++) begin
            tick();
            chk({tag, " hold_ab"}, {62'b0, outA, outB}, {62'b0, cur_ab});
            chk({tag, " hold_busy"}, {63'b0, busy}, 64'd1);
        end
        tick();
        chk({tag, " ab"}, {62'b0, outA, outB}, {62'b0, exp_ab});
        chk({tag, " pos"}, 64'(position), 64'(exp_pos));
        chk({tag, " done"}, {63'b0, done}, {63'b0, last});
        chk({tag, " busy"}, {63'b0, busy}, {63'b0, ~last});
        chk({tag, " ready"}, {63'b0, cmd_ready}, {63'b0, last});
        cur_ab = exp_ab;
    endtask

    task automatic accept(input logic dir, input int per, input int steps, input string tag);
        cmd_valid  = 1'b1;
        cmd_dir    = dir;
        cmd_period = PERIOD_W'(per);
        cmd_steps  = STEPS_W'(steps);
        tick();
        cmd_valid  = 1'b0;
        chk({tag, " acc_busy"}, {63'b0, busy}, 64'd1);
        chk({tag, " acc_ready"}, {63'b0, cmd_ready}, 64'd0);
        chk({tag, " acc_done"}, {63'b0, done}, 64'd0);
    endtask

    task automatic done_clears(input string tag);
        tick();
        chk({tag, " done_low"}, {63'b0, done}, 64'd0);
        chk({tag, " idle_busy"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        cur_ab     = 2'b00;
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dir    = 1'b0;
        cmd_period = '0;
        cmd_steps  = '0;
        stop       = 1'b0;

        // Reset state
        tick();
        chk("rst ab", {62'b0, outA, outB}, 64'd0);
        chk("rst pos", 64'(position), 64'd0);
        chk("rst busy", {63'b0, busy}, 64'd0);
        chk("rst done", {63'b0, done}, 64'd0);
        chk("rst ready", {63'b0, cmd_ready}, 64'd1);
        #2 reset_n = 1'b1;
        tick();
        chk("post_rst ready", {63'b0, cmd_ready}, 64'd1);

        // Forward, period 4, 4 edges: 01,11,10,00
        accept(1'b1, 4, 4, "fwd4");
        wait_edge(4, 2'b01, 1, 1'b0, "fwd4 e1");
        wait_edge(4, 2'b11, 2, 1'b0, "fwd4 e2");
        wait_edge(4, 2'b10, 3, 1'b0, "fwd4 e3");
        wait_edge(4, 2'b00, 4, 1'b1, "fwd4 e4");
        done_clears("fwd4");

        // Reverse, period 3, 2 edges continuing from 00: 10,11
        accept(1'b0, 3, 2, "rev3");
        wait_edge(3, 2'b10, 3, 1'b0, "rev3 e1");
        wait_edge(3, 2'b11, 2, 1'b1, "rev3 e2");
        done_clears("rev3");

        // Continuous forward, period 5, stop sampled 23 cycles after accept
        accept(1'b1, 5, 0, "cont");
        wait_edge(5, 2'b10, 3, 1'b0, "cont e1");
        wait_edge(5, 2'b00, 4, 1'b0, "cont e2");
        wait_edge(5, 2'b01, 5, 1'b0, "cont e3");
        wait_edge(5, 2'b11, 6, 1'b0, "cont e4");
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("cont stop done", {63'b0, done}, 64'd1);
        chk("cont stop busy", {63'b0, busy}, 64'd0);
        chk("cont stop ab", {62'b0, outA, outB}, {62'b0, 2'b11});
        chk("cont stop pos", 64'(position), 64'd6);
        done_clears("cont");

        // Stop landing exactly on a due edge: edge suppressed
        accept(1'b1, 5, 0, "stopedge");
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stopedge ab", {62'b0, outA, outB}, {62'b0, 2'b11});
        chk("stopedge pos", 64'(position), 64'd6);
        chk("stopedge done", {63'b0, done}, 64'd1);
        done_clears("stopedge");

        // stop in IDLE is ignored; stop with cmd_valid still accepts
        stop = 1'b1;
        tick();
        chk("idle stop ready", {63'b0, cmd_ready}, 64'd1);
        chk("idle stop done", {63'b0, done}, 64'd0);
        accept(1'b1, 0, 3, "per0");
        stop = 1'b0;
        // Period 0 clamps to 2: from 11 forward 10,00,01, done at k+6
        wait_edge(2, 2'b10, 7, 1'b0, "per0 e1");
        wait_edge(2, 2'b00, 8, 1'b0, "per0 e2");
        wait_edge(2, 2'b01, 9, 1'b1, "per0 e3");
        done_clears("per0");

        // Period 1 clamps to 2: reverse from 01 -> 00,10,11
        accept(1'b0, 1, 3, "per1");
        wait_edge(2, 2'b00, 8, 1'b0, "per1 e1");
        wait_edge(2, 2'b10, 7, 1'b0, "per1 e2");
        wait_edge(2, 2'b11, 6, 1'b1, "per1 e3");
        done_clears("per1");

        // cmd_valid held through a run: re-accept the cycle after done
        cmd_valid  = 1'b1;
        cmd_dir    = 1'b1;
        cmd_period = PERIOD_W'(2);
        cmd_steps  = STEPS_W'(2);
        tick();
        chk("hold acc_busy", {63'b0, busy}, 64'd1);
        chk("hold acc_ready", {63'b0, cmd_ready}, 64'd0);
        wait_edge(2, 2'b10, 7, 1'b0, "hold e1");
        wait_edge(2, 2'b00, 8, 1'b1, "hold e2");
        tick();
        cmd_valid = 1'b0;
        chk("hold reacc_busy", {63'b0, busy}, 64'd1);
        chk("hold reacc_ready", {63'b0, cmd_ready}, 64'd0);
        chk("hold reacc_done", {63'b0, done}, 64'd0);
        wait_edge(2, 2'b01, 9, 1'b0, "hold2 e1");
        wait_edge(2, 2'b11, 10, 1'b1, "hold2 e2");
        done_clears("hold2");

        // Asynchronous reset in the middle of a continuous run
        accept(1'b1, 4, 0, "arst");
        wait_edge(4, 2'b10, 11, 1'b0, "arst e1");
        tick();
        #3 reset_n = 1'b0;
        #1;
        chk("arst ab", {62'b0, outA, outB}, 64'd0);
        chk("arst pos", 64'(position), 64'd0);
        chk("arst busy", {63'b0, busy}, 64'd0);
        chk("arst done", {63'b0, done}, 64'd0);
        chk("arst ready", {63'b0, cmd_ready}, 64'd1);
        cur_ab = 2'b00;
        tick();
        chk("arst held done", {63'b0, done}, 64'd0);
        #2 reset_n = 1'b1;
        accept(1'b1, 2, 1, "after_rst");
        wait_edge(2, 2'b01, 1, 1'b1, "after_rst e1");
        done_clears("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quad_encoder_gen.md
# quad_encoder_gen

Quadrature encoder emulator: produces A/B signals equivalent to a motor encoder from a commanded direction, edge period and edge count. It sits on the stimulus side of the encoder path. It drives the same A/B inputs a physical encoder would, for hardware-in-the-loop tests and bench self-check of the speed/direction measurement logic. It also keeps a signed running position of the edges it has emitted.

## Interface
- PERIOD_W, 16, width of the edge-period field, in clock cycles per quadrature edge.
- STEPS_W, 16, width of the edge-count field.
- POS_W, 32, width of the signed position counter.

- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block accepts a command (high only in IDLE).
- cmd_dir  in  1  1 = forward, 0 = reverse.
- cmd_period  in  PERIOD_W  clock cycles between successive quadrature edges.
- cmd_steps  in  STEPS_W  number of quadrature edges to emit; 0 = continuous.
- stop  in  1  aborts the run.
- outA, outB  out  1  quadrature outputs, registered.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a run ends, whether by completion or stop.
- position  out  POS_W  signed count of edges emitted: +1 per forward edge, −1 per reverse edge.

## Operation
- States: IDLE and RUN.
- IDLE → RUN on the cycle where cmd_valid && cmd_ready.
  - On acceptance, latch dir, period, steps and set div = 0.
- Period clamp: a latched period below 2 is forced to 2.
- RUN: div increments every cycle. When div == period−1:
  - div returns to 0.
  - The phase advances one step in the latched direction.
  - position changes by ±1.
  - remaining decrements, unless in continuous mode.
- Phase sequence (A,B):
  - forward: 00→01→11→10→00 (B leads A; B is high at each rising edge of A).
  - reverse: 00→10→11→01→00.
- Exactly one of A/B changes per edge. The phase persists across commands and direction changes; it is never reset between runs.
- RUN → IDLE after the edge that brings remaining to 0. That edge is emitted, and done pulses on the same clock.
- stop sampled high in RUN: RUN → IDLE on the next edge with a done pulse. Any edge due that cycle is suppressed, and position is unchanged for it.
- stop in IDLE is ignored.
- stop and cmd_valid together in IDLE: the command is accepted and stop is ignored.
- position wraps modulo 2^POS_W (two's complement), with no saturation.
- Continuous mode (steps 0) runs until stop.
- Reset (asynchronous, any state):
  - state IDLE.
  - outA = outB = 0 (phase 00).
  - position = 0, busy = 0, done = 0, cmd_ready = 1.
  - div and remaining cleared.
- After reset is released, cmd_ready = 1 from the first clock.

## Timing
- Command accepted at rising edge k: busy = 1 and cmd_ready = 0 from edge k.
- Edge n (n = 1…N) appears on outA/outB at edge k + n·period. position updates at the same edge.
- Finite run of N edges: the last edge, busy → 0, cmd_ready → 1 and done → 1 all occur at edge k + N·period. done is low again at the next edge.
- A new command may be accepted in the cycle right after done.
- stop high sampled at edge m: busy → 0 and done → 1 at edge m. No output change at edge m.
- Output edges are spaced exactly period cycles apart, with no jitter, including across the phase wrap.

## Test plan
- Reset, then command fwd, period 4, steps 4 at edge 0:
  - A/B go 01, 11, 10, 00 at edges 4, 8, 12, 16.
  - position ends at 4.
  - done pulses at edge 16, busy low from edge 16.
- Then command rev, period 3, steps 2:
  - phase continues from 00: A/B go 10, 11 at +3 and +6.
  - position ends at 2.
  - No glitch on the unchanged signal.
- Continuous run (steps 0, fwd, period 5), stop asserted 23 cycles after acceptance:
  - exactly 4 edges emitted, position = +4.
  - one done pulse; no edge in the stop cycle.
- cmd_period = 0 and cmd_period = 1, steps 3: edges every 2 cycles, and the run completes at k+6.
- reset_n low mid-run, asynchronous between clocks:
  - outA/outB/position/busy clear immediately, with no done pulse.
  - after release, a new command is accepted at once.
- cmd_valid held high through a run: no second acceptance until cmd_ready returns, then immediate re-acceptance the cycle after done.
